drp_responder: RTL and testbench
================================

Name: drp_responder

Overview:
- DRP target (responder) that terminates the 7-bit-address / 16-bit-data dynamic reconfiguration port driven by the register-mapped DRP initiator.
- Implements a configuration word bank with fixed response latency and a single-cycle drdy strobe.
- Models MMCM-style reset and lock behaviour, so host-side DRP sequences can run against custom clocking logic, or in simulation without a vendor primitive.
- Exports the bank to downstream logic through a read-only side port.

Parameters:
- pDEPTH, 32, number of implemented 16-bit words (addresses 0..pDEPTH-1); range 1..128.
- pLATENCY, 3, cycles from the den sample edge to drdy high; range 1..15.
- pLOCK_CYCLES, 64, cycles of drp_reset low before locked rises; range 1..65535.

Ports:
- clk_usb  in  1  single clock; all logic on its rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- drp_addr  in  7  DRP address.
- drp_den  in  1  DRP enable; one-cycle request strobe.
- drp_dwe  in  1  write enable, qualified by drp_den.
- drp_din  in  16  write data.
- drp_dout  out  16  read data; valid while drp_drdy is high, held afterwards.
- drp_drdy  out  1  one-cycle response strobe.
- drp_reset  in  1  synchronous reset of the modelled clock block (not of the bank).
- locked  out  1  lock indication.
- err_overlap  out  1  sticky: den arrived while a transaction was outstanding.
- cfg_dirty  out  1  sticky: bank written while drp_reset was low.
- cfg_addr  in  7  side-port read address.
- cfg_data  out  16  side-port read data; combinational from the bank, 0 when out of range.

Behaviour:
- reset_i high (asynchronous): every bank word = 0, state IDLE, drp_dout = 0, drp_drdy = 0, locked = 0, lock counter = 0, err_overlap = 0, cfg_dirty = 0. An outstanding transaction is dropped; drp_drdy must not assert for it after release.
- FSM states: IDLE, BUSY. A latency counter lat_cnt is 4 bits wide.
- IDLE and drp_den = 1 at edge k:
  - capture addr, dwe and din.
  - if dwe = 1 and addr < pDEPTH, write bank[addr] <= din at edge k.
  - lat_cnt <= 1, go to BUSY.
- BUSY: lat_cnt increments each edge.
  - When lat_cnt = pLATENCY, at edge k+pLATENCY: drp_drdy <= 1 for exactly one cycle; drp_dout <= bank[captured addr] on a read, or 0 if addr >= pDEPTH; return to IDLE.
  - With pLATENCY = 1, drp_drdy is high in the cycle immediately after den.
- A write response leaves drp_dout unchanged. Reads of addresses >= pDEPTH return 0. Writes to addresses >= pDEPTH are ignored but still answered with drdy.
- drp_den in the same cycle drp_drdy is high is a legal new request and is accepted (back-to-back operation).
- drp_den while in BUSY (excluding the drdy cycle):
  - request ignored, bank unchanged, no extra drdy.
  - err_overlap <= 1 and stays set until reset_i.
- drp_dwe without drp_den is ignored.
- drp_reset:
  - Sampled synchronously; bank contents are retained and DRP transactions are still serviced during drp_reset.
  - While drp_reset = 1: locked = 0 in the following cycle, lock counter = 0, cfg_dirty <= 0.
  - While drp_reset = 0: lock counter increments, saturating at pLOCK_CYCLES; locked = 1 when the counter equals pLOCK_CYCLES (registered).
  - After reset_i release with drp_reset low, counting starts at the first edge.
- A write accepted while drp_reset = 0 sets cfg_dirty = 1. It does not drop locked.
- drp_reset = 1 and a write in the same cycle: the write is applied, cfg_dirty stays 0.
- Lock counter width is 16 bits; it must never wrap.

Decomposition:
- Package drp_pkg holds: DRP_ADDR_W = 7, DRP_DATA_W = 16, LOCK_CNT_W = 16, and the FSM state encoding (IDLE = 0, BUSY = 1).
- Sub-module drp_lock_timer owns the saturating lock counter and the locked register.
  - Inputs: clk_usb, reset_i, drp_reset.
  - Output: locked.
  - Parameter: pLOCK_CYCLES.
- The bank is a flop array sized by pDEPTH. No RAM inference is required.

Test Plan:
- Write, then read, in range:
  - den/dwe = 1, addr = 0x05, din = 0x1234 at cycle 0 (pLATENCY = 3) -> drdy high only in cycle 3, dout unchanged.
  - read of addr 0x05 -> drdy 3 cycles later, dout = 0x1234; cfg_addr = 5 -> cfg_data = 0x1234.
- Out of range: write 0xBEEF to addr 0x28 (pDEPTH = 32), then read 0x28 -> both answered with one drdy each, dout = 0x0000, cfg_data for 0x28 = 0.
- Back-to-back and overlap:
  - den on the drdy cycle -> accepted, second drdy pLATENCY cycles later, err_overlap = 0.
  - den one cycle after a request -> no drdy for it, target word unchanged, err_overlap = 1 until reset_i.
- Lock sequence:
  - drp_reset = 1 for 5 cycles, then 0 (pLOCK_CYCLES = 64) -> locked low throughout, rises exactly 64 cycles after release.
  - drp_reset re-asserted -> locked low next cycle.
- Dirty flag:
  - write while locked -> cfg_dirty = 1.
  - drp_reset pulse -> cfg_dirty = 0.
  - write during drp_reset -> cfg_dirty stays 0 and the data is stored.
- Async reset mid-transaction: read issued, reset_i pulsed asynchronously between clock edges one cycle later -> all bank words 0, no drdy for the dropped request, locked = 0, err_overlap = 0, cfg_dirty = 0.

Source files
------------

// File: rtl/drp_responder_pkg.sv
// Shared widths and FSM encoding for the DRP responder slice.
package drp_pkg;

    localparam int DRP_ADDR_W = 7;
    localparam int DRP_DATA_W = 16;
    localparam int LOCK_CNT_W = 16;
    localparam int LAT_CNT_W  = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } drp_state_e;

    // Widened compare so depth 128 does not overflow the 7-bit address space.
    function automatic logic addr_in_range(input logic [DRP_ADDR_W-1:0] addr,
                                           input int depth);
        return ({1'b0, addr} < 8'(depth));
    endfunction

endpackage

// File: rtl/drp_responder_if.sv
// DRP bus between an initiator (master) and a responder (slave).
interface drp_responder_if;

    logic [drp_pkg::DRP_ADDR_W-1:0] drp_addr;
    logic                           drp_den;
    logic                           drp_dwe;
    logic [drp_pkg::DRP_DATA_W-1:0] drp_din;
    logic [drp_pkg::DRP_DATA_W-1:0] drp_dout;
    logic                           drp_drdy;

    modport master (
        output drp_addr, drp_den, drp_dwe, drp_din,
        input  drp_dout, drp_drdy
    );

    modport slave (
        input  drp_addr, drp_den, drp_dwe, drp_din,
        output drp_dout, drp_drdy
    );

endinterface

// File: rtl/drp_lock_timer.sv
// Saturating lock counter modelling an MMCM lock delay after drp_reset falls.
module drp_lock_timer
    import drp_pkg::*;
#(
    parameter int pLOCK_CYCLES = 64
) (
    input  logic clk_usb,
    input  logic reset_i,
    input  logic drp_reset,
    output logic locked
);

    localparam logic [LOCK_CNT_W-1:0] LOCK_C = LOCK_CNT_W'(pLOCK_CYCLES);

    logic [LOCK_CNT_W-1:0] cnt_q, cnt_d;
    logic                  locked_q, locked_d;

    // Next counter and lock state; the counter holds once it reaches the target.
    always_comb begin
        cnt_d    = cnt_q;
        locked_d = locked_q;
        if (drp_reset) begin
            cnt_d    = '0;
            locked_d = 1'b0;
        end else begin
            if (cnt_q == LOCK_C) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
            locked_d = (cnt_d == LOCK_C);
        end
    end

    // Counter and lock registers.
    always_ff @(posedge clk_usb or posedge reset_i) begin
        if (reset_i) begin
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
        end
    end

    assign locked = locked_q;

endmodule

// File: rtl/drp_responder.sv
// DRP target: flop-based configuration bank with fixed response latency,
// modelled lock behaviour and a combinational read-only side port.
module drp_responder
    import drp_pkg::*;
#(
    parameter int pDEPTH       = 32,
    parameter int pLATENCY     = 3,
    parameter int pLOCK_CYCLES = 64
) (
    input  logic                  clk_usb,
    input  logic                  reset_i,
    drp_responder_if.slave        drp,
    input  logic                  drp_reset,
    output logic                  locked,
    output logic                  err_overlap,
    output logic                  cfg_dirty,
    input  logic [DRP_ADDR_W-1:0] cfg_addr,
    output logic [DRP_DATA_W-1:0] cfg_data
);

    localparam int                   IDX_W = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;
    localparam logic [LAT_CNT_W-1:0] LAT_C = LAT_CNT_W'(pLATENCY);

    drp_state_e            state_q, state_d;
    logic [LAT_CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [DRP_ADDR_W-1:0] cap_addr_q, cap_addr_d;
    logic                  cap_dwe_q, cap_dwe_d;
    logic [DRP_DATA_W-1:0] dout_q, dout_d;
    logic                  drdy_q, drdy_d;
    logic                  err_q, err_d;
    logic                  dirty_q, dirty_d;
    logic [DRP_DATA_W-1:0] bank_q [pDEPTH];

    logic accept_s, overlap_s, respond_s, bank_we_s;

    // FSM state register.
    always_ff @(posedge clk_usb or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        case (state_q)
            IDLE:    state_d = accept_s  ? BUSY : IDLE;
            BUSY:    state_d = respond_s ? IDLE : BUSY;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; the drdy cycle is already IDLE, so a den there is accepted.
    always_comb begin
        accept_s  = (state_q == IDLE) && drp.drp_den;
        overlap_s = (state_q == BUSY) && drp.drp_den;
        respond_s = (state_q == BUSY) && (lat_cnt_q == LAT_C);
        bank_we_s = accept_s && drp.drp_dwe && addr_in_range(drp.drp_addr, pDEPTH);
    end

    // Datapath next values: capture, latency count, response and sticky flags.
    always_comb begin
        lat_cnt_d  = lat_cnt_q;
        cap_addr_d = cap_addr_q;
        cap_dwe_d  = cap_dwe_q;
        dout_d     = dout_q;
        drdy_d     = 1'b0;
        err_d      = err_q | overlap_s;
        if (accept_s) begin
            lat_cnt_d  = 4'd1;
            cap_addr_d = drp.drp_addr;
            cap_dwe_d  = drp.drp_dwe;
        end else if (respond_s) begin
            drdy_d = 1'b1;
            if (cap_dwe_q) begin
                dout_d = dout_q;
            end else if (addr_in_range(cap_addr_q, pDEPTH)) begin
                dout_d = bank_q[cap_addr_q[IDX_W-1:0]];
            end else begin
                dout_d = '0;
            end
        end else if (state_q == BUSY) begin
            lat_cnt_d = lat_cnt_q + 4'd1;
        end else begin
            lat_cnt_d = lat_cnt_q;
        end

        if (drp_reset) begin
            dirty_d = 1'b0;
        end else if (bank_we_s) begin
            dirty_d = 1'b1;
        end else begin
            dirty_d = dirty_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_usb or posedge reset_i) begin
        if (reset_i) begin
            lat_cnt_q  <= '0;
            cap_addr_q <= '0;
            cap_dwe_q  <= 1'b0;
            dout_q     <= '0;
            drdy_q     <= 1'b0;
            err_q      <= 1'b0;
            dirty_q    <= 1'b0;
        end else begin
            lat_cnt_q  <= lat_cnt_d;
            cap_addr_q <= cap_addr_d;
            cap_dwe_q  <= cap_dwe_d;
            dout_q     <= dout_d;
            drdy_q     <= drdy_d;
            err_q      <= err_d;
            dirty_q    <= dirty_d;
        end
    end

    // Configuration bank; writes land on the accepting edge.
    always_ff @(posedge clk_usb or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < pDEPTH; i++) begin
                bank_q[i] <= '0;
            end
        end else if (bank_we_s) begin
            bank_q[drp.drp_addr[IDX_W-1:0]] <= drp.drp_din;
        end
    end

    // Side-port read.
    always_comb begin
        if (addr_in_range(cfg_addr, pDEPTH)) begin
            cfg_data = bank_q[cfg_addr[IDX_W-1:0]];
        end else begin
            cfg_data = '0;
        end
    end

    drp_lock_timer #(
        .pLOCK_CYCLES(pLOCK_CYCLES)
    ) u_lock_timer (
        .clk_usb  (clk_usb),
        .reset_i  (reset_i),
        .drp_reset(drp_reset),
        .locked   (locked)
    );

    assign drp.drp_dout = dout_q;
    assign drp.drp_drdy = drdy_q;
    assign err_overlap  = err_q;
    assign cfg_dirty    = dirty_q;

endmodule

// File: tb/tb_drp_responder.sv
// Directed bench for drp_responder with default parameters (depth 32, latency 3, lock 64).
module tb_drp_responder;

    logic        clk_usb;
    logic        reset_i;
    logic        drp_reset;
    logic        locked;
    logic        err_overlap;
    logic        cfg_dirty;
    logic [6:0]  cfg_addr;
    logic [15:0] cfg_data;

    int checks   = 0;
    int failures = 0;

    drp_responder_if bus ();

    drp_responder #(
        .pDEPTH      (32),
        .pLATENCY    (3),
        .pLOCK_CYCLES(64)
    ) dut (
        .clk_usb    (clk_usb),
        .reset_i    (reset_i),
        .drp        (bus),
        .drp_reset  (drp_reset),
        .locked     (locked),
        .err_overlap(err_overlap),
        .cfg_dirty  (cfg_dirty),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data)
    );

    initial begin
        clk_usb = 1'b0;
        forever #5 clk_usb = ~clk_usb;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_usb);
        #1;
    endtask

    task automatic do_req(input logic [6:0] a, input logic we, input logic [15:0] d);
        bus.drp_addr = a;
        bus.drp_dwe  = we;
        bus.drp_din  = d;
        bus.drp_den  = 1'b1;
        tick();
        bus.drp_den  = 1'b0;
        bus.drp_dwe  = 1'b0;
    endtask

    task automatic wait_drdy(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.drp_drdy !== 1'b1 && n < 20);
    endtask

    task automatic count_drdy(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            tick();
            if (bus.drp_drdy === 1'b1) n++;
        end
    endtask

    task automatic cfg_read(input logic [6:0] a, output logic [15:0] d);
        cfg_addr = a;
        #1;
        d = cfg_data;
    endtask

    initial begin
        int          n;
        logic [15:0] d;
        logic [15:0] acc;

        reset_i      = 1'b1;
        drp_reset    = 1'b1;
        bus.drp_addr = 7'd0;
        bus.drp_den  = 1'b0;
        bus.drp_dwe  = 1'b0;
        bus.drp_din  = 16'd0;
        cfg_addr     = 7'd0;
        repeat (3) tick();
        reset_i = 1'b0;
        tick();

        check("rst_drdy",   32'(bus.drp_drdy), 32'd0);
        check("rst_dout",   32'(bus.drp_dout), 32'd0);
        check("rst_locked", 32'(locked),       32'd0);
        check("rst_err",    32'(err_overlap),  32'd0);
        check("rst_dirty",  32'(cfg_dirty),    32'd0);

        // Lock sequence: drp_reset held for 5 cycles, then count to lock.
        repeat (4) tick();
        check("lock_held_low", 32'(locked), 32'd0);
        drp_reset = 1'b0;
        n = 0;
        while (locked !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("lock_rise_cycles", 32'(n), 32'd64);

        // Write 0x1234 to address 5 while locked.
        do_req(7'h05, 1'b1, 16'h1234);
        wait_drdy(n);
        check("wr5_latency",     32'(n),            32'd3);
        check("wr5_dout_kept",   32'(bus.drp_dout), 32'h0000);
        check("wr5_dirty",       32'(cfg_dirty),    32'd1);
        check("wr5_locked_kept", 32'(locked),       32'd1);
        tick();
        check("wr5_drdy_one_cycle", 32'(bus.drp_drdy), 32'd0);
        cfg_read(7'h05, d);
        check("cfg5_after_wr", 32'(d), 32'h1234);

        do_req(7'h05, 1'b0, 16'h0000);
        wait_drdy(n);
        check("rd5_latency", 32'(n),            32'd3);
        check("rd5_dout",    32'(bus.drp_dout), 32'h1234);

        // Out of range address 0x28.
        do_req(7'h28, 1'b1, 16'hBEEF);
        wait_drdy(n);
        check("wr28_latency",   32'(n),            32'd3);
        check("wr28_dout_kept", 32'(bus.drp_dout), 32'h1234);
        cfg_read(7'h28, d);
        check("cfg28_zero", 32'(d), 32'h0000);
        do_req(7'h28, 1'b0, 16'h0000);
        wait_drdy(n);
        check("rd28_latency", 32'(n),            32'd3);
        check("rd28_dout",    32'(bus.drp_dout), 32'h0000);

        // Back-to-back: new den during the drdy cycle.
        do_req(7'h07, 1'b1, 16'h00AA);
        wait_drdy(n);
        check("wr7_latency", 32'(n), 32'd3);
        do_req(7'h07, 1'b0, 16'h0000);
        wait_drdy(n);
        check("b2b_latency", 32'(n),            32'd3);
        check("b2b_dout",    32'(bus.drp_dout), 32'h00AA);
        check("b2b_no_err",  32'(err_overlap),  32'd0);

        // Overlap: second den one cycle after a request.
        tick();
        do_req(7'h03, 1'b0, 16'h0000);
        do_req(7'h07, 1'b1, 16'h5555);
        wait_drdy(n);
        check("ovl_first_latency", 32'(n),            32'd2);
        check("ovl_first_dout",    32'(bus.drp_dout), 32'h0000);
        count_drdy(6, n);
        check("ovl_no_extra_drdy", 32'(n), 32'd0);
        cfg_read(7'h07, d);
        check("ovl_word_kept", 32'(d),           32'h00AA);
        check("ovl_err_set",   32'(err_overlap), 32'd1);

        // Dirty flag cleared by drp_reset; write during drp_reset keeps it clear.
        drp_reset = 1'b1;
        tick();
        check("drst_locked_low", 32'(locked),    32'd0);
        check("drst_dirty_clr",  32'(cfg_dirty), 32'd0);
        do_req(7'h09, 1'b1, 16'h0F0F);
        wait_drdy(n);
        check("drst_wr_latency",  32'(n),           32'd3);
        check("drst_dirty_stays", 32'(cfg_dirty),   32'd0);
        check("drst_err_sticky",  32'(err_overlap), 32'd1);
        cfg_read(7'h09, d);
        check("drst_wr_stored", 32'(d), 32'h0F0F);
        drp_reset = 1'b0;
        tick();

        // Asynchronous reset one cycle after a read is issued.
        do_req(7'h05, 1'b0, 16'h0000);
        tick();
        #2 reset_i = 1'b1;
        #2 reset_i = 1'b0;
        check("arst_locked", 32'(locked),       32'd0);
        check("arst_err",    32'(err_overlap),  32'd0);
        check("arst_dirty",  32'(cfg_dirty),    32'd0);
        check("arst_dout",   32'(bus.drp_dout), 32'd0);
        count_drdy(8, n);
        check("arst_no_drdy", 32'(n), 32'd0);
        acc = 16'h0000;
        for (int i = 0; i < 32; i++) begin
            cfg_read(7'(i), d);
            acc = acc | d;
        end
        check("arst_bank_zero", 32'(acc), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
